// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// ex_stage_if
// Bundles every signal crossing the execute-stage boundary, other than clock
// and reset.
//   ID/EX side : pc_e, pc_plus4_e, imm_ext_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e,
//                reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e,
//                jump_reg_e, alu_sel_e, funct3_e, result_src_e
//   Hazard     : forward_a_e, forward_b_e, result_w
//   Redirect   : pc_src_e, pc_target_e (combinational)
//   EX/MEM     : alu_result_m, write_data_m, pc_plus4_m, rd_m, reg_write_m,
//                mem_write_m, result_src_m (registered)
// The master modport drives the stage; the slave modport is the stage itself.
// ---------------------------------------------------------------------------
interface ex_stage_if;
    logic [31:0] pc_e;
    logic [31:0] pc_plus4_e;
    logic [31:0] imm_ext_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic        reg_write_e;
    logic        alu_src_e;
    logic        mem_write_e;
    logic        branch_e;
    logic        jump_e;
    logic        jump_reg_e;
    logic [3:0]  alu_sel_e;
    logic [2:0]  funct3_e;
    logic [1:0]  result_src_e;
    logic [1:0]  forward_a_e;
    logic [1:0]  forward_b_e;
    logic [31:0] result_w;

    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [31:0] pc_plus4_m;
    logic [4:0]  rd_m;
    logic        reg_write_m;
    logic        mem_write_m;
    logic [1:0]  result_src_m;

    modport master (
        output pc_e, pc_plus4_e, imm_ext_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e,
               reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e,
               jump_reg_e, alu_sel_e, funct3_e, result_src_e,
               forward_a_e, forward_b_e, result_w,
        input  pc_src_e, pc_target_e, alu_result_m, write_data_m, pc_plus4_m,
               rd_m, reg_write_m, mem_write_m, result_src_m
    );

    modport slave (
        input  pc_e, pc_plus4_e, imm_ext_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e,
               reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e,
               jump_reg_e, alu_sel_e, funct3_e, result_src_e,
               forward_a_e, forward_b_e, result_w,
        output pc_src_e, pc_target_e, alu_result_m, write_data_m, pc_plus4_m,
               rd_m, reg_write_m, mem_write_m, result_src_m
    );
endinterface

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage of the five-stage RISC-V pipeline: operand forwarding, ALU,
// branch/jump resolution and the EX/MEM pipeline register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the EX/MEM register
//   ex_if : ex_stage_if.slave, ID/EX inputs, forwarding controls, redirect
//           outputs and the registered EX/MEM outputs
// ---------------------------------------------------------------------------
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    ex_stage_if.slave   ex_if
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_LUI  = 4'b1010
    } alu_op_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  result_src;
    } ex_mem_t;

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        branch_cond;
    ex_mem_t     ex_mem_d, ex_mem_q;

    // Forwarding: 10 takes the EX/MEM flop output (previous instruction), so
    // there is no combinational path from alu_result back into src_a/src_b.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        src_a = ex_if.rd1_e;
        unique case (ex_if.forward_a_e)
            2'b01:   src_a = ex_if.result_w;
            2'b10:   src_a = ex_mem_q.alu_result;
            default: src_a = ex_if.rd1_e;
        endcase

        fwd_b = ex_if.rd2_e;
        unique case (ex_if.forward_b_e)
            2'b01:   fwd_b = ex_if.result_w;
            2'b10:   fwd_b = ex_mem_q.alu_result;
            default: fwd_b = ex_if.rd2_e;
        endcase

        src_b = ex_if.alu_src_e ? ex_if.imm_ext_e : fwd_b;
    end

    always_comb begin
        alu_result = 32'h0;
        case (alu_op_e'(ex_if.alu_sel_e))
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLL:  alu_result = src_a << src_b[4:0];
            ALU_SRL:  alu_result = src_a >> src_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> src_b[4:0]);
            ALU_SLT:  alu_result = {31'h0, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {31'h0, src_a < src_b};
            ALU_LUI:  alu_result = src_b;
            default:  alu_result = 32'h0;
        endcase
    end

    // Branch compare always uses the register operands (never the immediate).
    always_comb begin
        branch_cond = 1'b0;
        case (ex_if.funct3_e)
            3'b000:  branch_cond = (src_a == fwd_b);
            3'b001:  branch_cond = (src_a != fwd_b);
            3'b100:  branch_cond = ($signed(src_a) <  $signed(fwd_b));
            3'b101:  branch_cond = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  branch_cond = (src_a <  fwd_b);
            3'b111:  branch_cond = (src_a >= fwd_b);
            default: branch_cond = 1'b0;
        endcase
    end

    // JALR target uses the forwarded rs1 and clears bit 0.
    assign ex_if.pc_target_e = ex_if.jump_reg_e ? ((src_a + ex_if.imm_ext_e) & ~32'h1)
                                                : (ex_if.pc_e + ex_if.imm_ext_e);
    assign ex_if.pc_src_e    = ex_if.jump_e | (ex_if.branch_e & branch_cond);

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.alu_result = alu_result;
        ex_mem_d.write_data = fwd_b;
        ex_mem_d.pc_plus4   = ex_if.pc_plus4_e;
        ex_mem_d.rd         = ex_if.rd_e;
        // Writes to x0 are dropped here so later stages never see them.
        ex_mem_d.reg_write  = ex_if.reg_write_e & (ex_if.rd_e != 5'd0);
        ex_mem_d.mem_write  = ex_if.mem_write_e;
        ex_mem_d.result_src = ex_if.result_src_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples its input from before the edge.
            ex_mem_q <= ex_mem_d;
        end
    end

    assign ex_if.alu_result_m = ex_mem_q.alu_result;
    assign ex_if.write_data_m = ex_mem_q.write_data;
    assign ex_if.pc_plus4_m   = ex_mem_q.pc_plus4;
    assign ex_if.rd_m         = ex_mem_q.rd;
    assign ex_if.reg_write_m  = ex_mem_q.reg_write;
    assign ex_if.mem_write_m  = ex_mem_q.mem_write;
    assign ex_if.result_src_m = ex_mem_q.result_src;

endmodule
